// File: rtl/ec_acc_pkg.sv
// ec_acc_pkg: geometry constants shared across the EC accelerator datapath
// (input buffer, multiplier array, output buffer) plus the output-buffer
// serializer state type.
//   BM_MULT_UNIT_NUM x W packets of PACKET_LENGTH bits form one parity row.
//   OUTBUF_DATA_W is the egress beat width; BEATS beats carry one row.
package ec_acc_pkg;

  localparam int BM_MULT_UNIT_NUM = 4;
  localparam int W                = 8;
  localparam int PACKET_LENGTH    = 8;
  localparam int ROW_W            = BM_MULT_UNIT_NUM * W * PACKET_LENGTH;

  localparam int OUTBUF_DATA_W    = 64;
  localparam int OUTBUF_DEPTH     = 4;
  localparam int BEATS            = ROW_W / OUTBUF_DATA_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } outbuf_state_t;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/output_buffer_if.sv
// output_buffer_if: controller-side row push/status signals and the egress
// valid/ready beat stream of the output buffer.
//   master : the output buffer itself (drives status and the beat stream)
//   slave  : controller + downstream sink (drive row pushes and ready)
interface output_buffer_if
  import ec_acc_pkg::*;
#(
  parameter int DATA_W = OUTBUF_DATA_W,
  parameter int DEPTH  = OUTBUF_DEPTH
);

  localparam int CNT_W = cnt_width(DEPTH);

  // controller -> buffer
  logic             cntl_outbuf_wr_req;
  logic [ROW_W-1:0] cntl_outbuf_wr_data;
  // buffer -> controller
  logic             outbuf_cntl_full;
  logic             outbuf_cntl_empty;
  logic [CNT_W-1:0] outbuf_cntl_cnt;
  logic             outbuf_cntl_ovf;
  // egress stream
  logic              outbuf_rd_rdy;
  logic              outbuf_dout_val;
  logic [DATA_W-1:0] outbuf_dout;
  logic              outbuf_dout_last;

  modport master (
    input  cntl_outbuf_wr_req, cntl_outbuf_wr_data, outbuf_rd_rdy,
    output outbuf_cntl_full, outbuf_cntl_empty, outbuf_cntl_cnt,
           outbuf_cntl_ovf, outbuf_dout_val, outbuf_dout, outbuf_dout_last
  );

  modport slave (
    output cntl_outbuf_wr_req, cntl_outbuf_wr_data, outbuf_rd_rdy,
    input  outbuf_cntl_full, outbuf_cntl_empty, outbuf_cntl_cnt,
           outbuf_cntl_ovf, outbuf_dout_val, outbuf_dout, outbuf_dout_last
  );

endinterface

// File: rtl/outbuf_row_fifo.sv
// outbuf_row_fifo: register-array FIFO holding whole parity rows.
//   clk, srst      : clock, synchronous active-high reset (flushes the FIFO)
//   push/push_data : write one row; ignored while full
//   pop/pop_data   : pop_data always shows the head row; pop ignored when empty
//   cnt/full/empty : registered occupancy, valid the cycle after push/pop
module outbuf_row_fifo
  import ec_acc_pkg::*;
#(
  parameter int DATA_W = ROW_W,
  parameter int DEPTH  = OUTBUF_DEPTH
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  output logic [DATA_W-1:0]           pop_data,
  output logic [cnt_width(DEPTH)-1:0] cnt,
  output logic                        full,
  output logic                        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;
  logic              full_reg;
  logic              empty_reg;
  logic              push_ok;
  logic              pop_ok;

  // Acceptance uses the registered flags, so a pop in the same cycle does
  // not make room for a push into a full FIFO.
  assign push_ok  = push & ~full_reg;
  assign pop_ok   = pop & ~empty_reg;
  assign cnt_next = cnt_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      cnt_reg   <= cnt_next;
      full_reg  <= (cnt_next == CNT_W'(DEPTH));
      empty_reg <= (cnt_next == '0);
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign cnt      = cnt_reg;
  assign full     = full_reg;
  assign empty    = empty_reg;

endmodule

// File: rtl/output_buffer.sv
// output_buffer: egress end of the EC accelerator datapath. Rows pushed by
// the controller are queued in a row FIFO, then serialized LSB-first onto a
// valid/ready beat stream, with last marking the final beat of each row.
//   clk : clock, rising edge
//   rst : synchronous active-high reset; discards any row in flight
//   bus : output_buffer_if.master
//         cntl_outbuf_wr_req/wr_data   row push from the controller
//         outbuf_cntl_full/empty/cnt   registered occupancy (cnt excludes
//                                      the row being serialized)
//         outbuf_cntl_ovf              sticky: push attempted while full
//         outbuf_rd_rdy, outbuf_dout_val/dout/dout_last  beat stream
module output_buffer
  import ec_acc_pkg::*;
#(
  parameter int OUTBUF_DATA_W_P = OUTBUF_DATA_W,
  parameter int OUTBUF_DEPTH_P  = OUTBUF_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  output_buffer_if.master bus
);

  localparam int BEATS_P = ROW_W / OUTBUF_DATA_W_P;
  localparam int IDX_W   = (BEATS_P > 1) ? $clog2(BEATS_P) : 1;
  localparam int CNT_W   = cnt_width(OUTBUF_DEPTH_P);

  outbuf_state_t    state_reg;
  logic [ROW_W-1:0] shift_reg;
  logic [IDX_W-1:0] beat_idx_reg;
  logic             val_reg;
  logic             ovf_reg;

  logic [ROW_W-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             last_beat;
  logic             beat_done;

  assign last_beat = (beat_idx_reg == IDX_W'(BEATS_P - 1));
  assign beat_done = val_reg & bus.outbuf_rd_rdy;

  // Load a row either from IDLE, or on the final handshake of the current
  // row so consecutive rows stream without a bubble.
  assign fifo_pop = ~fifo_empty &
                    ((state_reg == IDLE) | (beat_done & last_beat));

  outbuf_row_fifo #(
    .DATA_W (ROW_W),
    .DEPTH  (OUTBUF_DEPTH_P)
  ) u_row_fifo (
    .clk       (clk),
    .srst      (rst),
    .push      (bus.cntl_outbuf_wr_req),
    .push_data (bus.cntl_outbuf_wr_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .cnt       (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      beat_idx_reg <= '0;
      val_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (bus.cntl_outbuf_wr_req && fifo_full) begin
        ovf_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            shift_reg    <= fifo_head;
            beat_idx_reg <= '0;
            val_reg      <= 1'b1;
            state_reg    <= SEND;
          end
        end
        SEND: begin
          if (beat_done) begin
            if (last_beat) begin
              beat_idx_reg <= '0;
              if (!fifo_empty) begin
                shift_reg <= fifo_head;
              end else begin
                // Fully shifted out, so this leaves dout at zero while idle.
                shift_reg <= shift_reg >> OUTBUF_DATA_W_P;
                val_reg   <= 1'b0;
                state_reg <= IDLE;
              end
            end else begin
              shift_reg    <= shift_reg >> OUTBUF_DATA_W_P;
              beat_idx_reg <= beat_idx_reg + IDX_W'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          val_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.outbuf_dout       = shift_reg[OUTBUF_DATA_W_P-1:0];
  assign bus.outbuf_dout_val   = val_reg;
  assign bus.outbuf_dout_last  = val_reg & last_beat;
  assign bus.outbuf_cntl_full  = fifo_full;
  assign bus.outbuf_cntl_empty = fifo_empty & (state_reg == IDLE);
  assign bus.outbuf_cntl_cnt   = fifo_cnt;
  assign bus.outbuf_cntl_ovf   = ovf_reg;

endmodule
